// File: rtl/wide_add_sequencer_pkg.sv
// Shared definitions for the wide add/subtract sequencer: FSM encoding and NZPC flag indices.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wide_add_sequencer_pkg;

   localparam int HALF_W = 16;
   localparam int WIDE_W = 2 * HALF_W;

   // Sequencer states; the encodings are shared with the rest of the CPU.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      DONE = 2'd3
   } state_t;

   // Bit positions inside the {n,p,z,c} status register.
   localparam int FLAG_N = 3;
   localparam int FLAG_P = 2;
   localparam int FLAG_Z = 1;
   localparam int FLAG_C = 0;

endpackage

// File: rtl/wide_add_sequencer_if.sv
// Bundle of request, response and shared-adder signals around the sequencer.
// Latency: n/a (wiring only).
// Backpressure: req_valid/req_ready on the request side, resp_valid/resp_ready on the response side.
interface wide_add_sequencer_if #(
   parameter int HALF_W = 16
);

   logic                  req_valid;
   logic                  req_ready;
   logic [2*HALF_W-1:0]   req_op_a;
   logic [2*HALF_W-1:0]   req_op_b;
   logic                  req_sub;
   logic                  req_wide;

   logic [HALF_W-1:0]     add_a;
   logic [HALF_W-1:0]     add_b;
   logic                  add_cin;
   logic [HALF_W-1:0]     add_out;
   logic                  c_out;

   logic                  resp_valid;
   logic                  resp_ready;
   logic [2*HALF_W-1:0]   result;
   logic [3:0]            status_reg;
   logic                  busy;

   // Sequencer side: accepts requests, drives the adder, presents results.
   modport slave (
      input  req_valid, req_op_a, req_op_b, req_sub, req_wide,
      input  add_out, c_out, resp_ready,
      output req_ready, add_a, add_b, add_cin,
      output resp_valid, result, status_reg, busy
   );

   // Environment side: execute stage, shared adder and result consumer.
   modport master (
      output req_valid, req_op_a, req_op_b, req_sub, req_wide,
      output add_out, c_out, resp_ready,
      input  req_ready, add_a, add_b, add_cin,
      input  resp_valid, result, status_reg, busy
   );

endinterface

// File: rtl/wide_add_sequencer_flag_calc.sv
// Combinational {n,p,z,c} encoding of a finished add/subtract result.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module wide_add_sequencer_flag_calc
   import wide_add_sequencer_pkg::*;
#(
   parameter int HW = 16
) (
   input  logic [2*HW-1:0] res,
   input  logic            wide,
   input  logic            carry,
   output logic [3:0]      flags
);

   // Sign and zero look only at the active width; zero counts as positive.
   always_comb begin
      flags         = 4'b0000;
      flags[FLAG_N] = wide ? res[2*HW-1] : res[HW-1];
      flags[FLAG_P] = ~flags[FLAG_N];
      flags[FLAG_Z] = wide ? (res == '0) : (res[HW-1:0] == '0);
      flags[FLAG_C] = carry;
   end

endmodule

// File: rtl/wide_add_sequencer.sv
// Sequences the shared 16-bit adder for 16-bit (one pass) or 32-bit (two chained passes) add/sub.
// Latency: accept edge to resp_valid is 2 edges narrow, 3 edges wide.
// Backpressure: requests taken only in IDLE; result/status held in DONE until resp_ready.
module wide_add_sequencer
   import wide_add_sequencer_pkg::*;
#(
   parameter int HALF_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   wide_add_sequencer_if.slave  bus
);

   state_t               state;
   state_t               state_nxt;

   logic [2*HALF_W-1:0]  op_a;
   logic [2*HALF_W-1:0]  op_b;
   logic                 op_sub;
   logic                 op_wide;
   logic [HALF_W-1:0]    res_lo;
   logic                 carry;
   logic [2*HALF_W-1:0]  result_q;
   logic [3:0]           status_q;

   logic [2*HALF_W-1:0]  fin_res;
   logic [3:0]           fin_flags;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode; req_valid is only looked at in IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.req_valid) state_nxt = LO;
         LO:      state_nxt = op_wide ? HI : DONE;
         HI:      state_nxt = DONE;
         DONE:    if (bus.resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake and adder drives; B is pre-inverted and cin forced for subtract in the low pass.
   always_comb begin
      bus.req_ready  = (state == IDLE);
      bus.resp_valid = (state == DONE);
      bus.busy       = (state != IDLE);
      bus.add_a      = '0;
      bus.add_b      = '0;
      bus.add_cin    = 1'b0;
      case (state)
         LO: begin
            bus.add_a   = op_a[HALF_W-1:0];
            bus.add_b   = op_sub ? ~op_b[HALF_W-1:0] : op_b[HALF_W-1:0];
            bus.add_cin = op_sub;
         end
         HI: begin
            bus.add_a   = op_a[2*HALF_W-1:HALF_W];
            bus.add_b   = op_sub ? ~op_b[2*HALF_W-1:HALF_W] : op_b[2*HALF_W-1:HALF_W];
            bus.add_cin = carry;
         end
         default: ;
      endcase
   end

   // Candidate final result for the pass in flight: high pass joins with the saved low half.
   always_comb begin
      if (state == HI) begin
         fin_res = {bus.add_out, res_lo};
      end else begin
         fin_res = {{HALF_W{1'b0}}, bus.add_out};
      end
   end

   wide_add_sequencer_flag_calc #(
      .HW    (HALF_W)
   ) u_flag_calc (
      .res   (fin_res),
      .wide  (op_wide),
      .carry (bus.c_out),
      .flags (fin_flags)
   );

   // Operand latch, per-pass capture, and architectural result/status update on entry to DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a     <= '0;
         op_b     <= '0;
         op_sub   <= 1'b0;
         op_wide  <= 1'b0;
         res_lo   <= '0;
         carry    <= 1'b0;
         result_q <= '0;
         status_q <= 4'b0000;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  op_a    <= bus.req_op_a;
                  op_b    <= bus.req_op_b;
                  op_sub  <= bus.req_sub;
                  op_wide <= bus.req_wide;
               end
            end
            LO: begin
               res_lo <= bus.add_out;
               carry  <= bus.c_out;
               if (!op_wide) begin
                  result_q <= fin_res;
                  status_q <= fin_flags;
               end
            end
            HI: begin
               carry    <= bus.c_out;
               result_q <= fin_res;
               status_q <= fin_flags;
            end
            default: ;
         endcase
      end
   end

   assign bus.result     = result_q;
   assign bus.status_reg = status_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer: directed table, corner sequences, random vs. model.
// Latency: n/a.
// Backpressure: exercised by holding resp_ready low in DONE.
module tb_wide_add_sequencer;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   wide_add_sequencer_if #(.HALF_W(16)) bus ();

   wide_add_sequencer #(.HALF_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Shared adder stand-in.
   assign {bus.c_out, bus.add_out} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {16'd0, bus.add_cin};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic        wide;
      logic [31:0] exp_res;
      logic [3:0]  exp_st;
      int          exp_lat;
   } vec_t;

   vec_t vecs [8];

   logic [15:0] lo_a, lo_b, hi_a, hi_b;
   logic        lo_cin, lo_cout, hi_cin;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Reference: plain arithmetic at the active width.
   function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                 input logic wide, output logic [31:0] r, output logic [3:0] st);
      logic [32:0] av, bv, s;
      logic        n, z, c;
      av = wide ? {1'b0, a} : {17'd0, a[15:0]};
      bv = wide ? {1'b0, b} : {17'd0, b[15:0]};
      if (sub) begin
         s = av - bv;
         c = (av >= bv);
      end else begin
         s = av + bv;
         c = wide ? s[32] : s[16];
      end
      r = wide ? s[31:0] : {16'd0, s[15:0]};
      n = wide ? r[31] : r[15];
      z = (r == 32'd0);
      st = {n, ~n, z, c};
   endfunction

   // One full transaction from IDLE, sampling adder drives in each pass, then drain.
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s, input logic w,
                        output logic [31:0] r, output logic [3:0] st, output int lat);
      bit ok;
      @(negedge clk);
      bus.req_op_a  = a;
      bus.req_op_b  = b;
      bus.req_sub   = s;
      bus.req_wide  = w;
      bus.req_valid = 1'b1;
      @(posedge clk);
      lat = 1;
      ok  = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (k == 0) begin
            lo_a = bus.add_a; lo_b = bus.add_b; lo_cin = bus.add_cin; lo_cout = bus.c_out;
            bus.req_valid = 1'b0;
         end
         if (k == 1) begin
            hi_a = bus.add_a; hi_b = bus.add_b; hi_cin = bus.add_cin;
         end
         if (bus.resp_valid) begin
            ok = 1;
            break;
         end
         @(posedge clk);
         lat++;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL resp_timeout: got no resp_valid within 10 edges, required resp_valid");
      end
      r  = bus.result;
      st = bus.status_reg;
      bus.resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.resp_ready = 1'b0;
   endtask

   initial begin
      logic [31:0] r, ra, rb, hold_res, exp_r;
      logic [3:0]  st, hold_st, exp_st;
      int          lat;

      checks = 0;
      errors = 0;
      bus.req_valid  = 1'b0;
      bus.req_op_a   = '0;
      bus.req_op_b   = '0;
      bus.req_sub    = 1'b0;
      bus.req_wide   = 1'b0;
      bus.resp_ready = 1'b0;

      vecs[0] = '{32'h0000_7FFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_8000, 4'b1000, 2};
      vecs[1] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h0001_0000, 4'b0100, 3};
      vecs[2] = '{32'h0001_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h0000_FFFF, 4'b0101, 3};
      vecs[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0000, 4'b0111, 3};
      vecs[4] = '{32'hABCD_0001, 32'hABCD_FFFF, 1'b0, 1'b0, 32'h0000_0000, 4'b0111, 2};
      vecs[5] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'h0000_FFFE, 4'b1000, 2};
      vecs[6] = '{32'h0000_0007, 32'h0000_0007, 1'b1, 1'b0, 32'h0000_0000, 4'b0111, 2};
      vecs[7] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'hFFFF_FFFF, 4'b1000, 3};

      // Reset state.
      rst_n = 1'b0;
      #12;
      chk("rst_result", bus.result, 32'd0);
      chk("rst_status", {28'd0, bus.status_reg}, 32'd0);
      chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_add_drv", {15'd0, bus.add_cin, bus.add_a}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);

      // Directed table.
      for (int i = 0; i < 8; i++) begin
         do_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].wide, r, st, lat);
         chk($sformatf("vec%0d_result", i), r, vecs[i].exp_res);
         chk($sformatf("vec%0d_status", i), {28'd0, st}, {28'd0, vecs[i].exp_st});
         chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
         if (i == 1) begin
            chk("vec1_lo_cin", {31'd0, lo_cin}, 32'd0);
            chk("vec1_lo_cout", {31'd0, lo_cout}, 32'd1);
            chk("vec1_hi_cin", {31'd0, hi_cin}, 32'd1);
         end
         if (i == 2) begin
            chk("vec2_lo_b", {16'd0, lo_b}, 32'h0000_FFFE);
            chk("vec2_lo_cin", {31'd0, lo_cin}, 32'd1);
            chk("vec2_hi_b", {16'd0, hi_b}, 32'h0000_FFFF);
            chk("vec2_hi_a", {16'd0, hi_a}, 32'h0000_0001);
         end
         if (i == 4) begin
            chk("vec4_lo_a", {16'd0, lo_a}, 32'h0000_0001);
         end
      end

      // Backpressure: hold DONE for 5 cycles with a new request pending.
      @(negedge clk);
      bus.req_op_a = 32'h0000_7FFF; bus.req_op_b = 32'h0000_0001;
      bus.req_sub = 1'b0; bus.req_wide = 1'b0; bus.req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("bp_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
      hold_res = bus.result;
      hold_st  = bus.status_reg;
      chk("bp_first_result", hold_res, 32'h0000_8000);
      bus.req_op_a = 32'h0000_1234; bus.req_op_b = 32'h0000_1111; bus.req_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("bp_hold%0d_result", c), bus.result, hold_res);
         chk($sformatf("bp_hold%0d_status", c), {28'd0, bus.status_reg}, {28'd0, hold_st});
         chk($sformatf("bp_hold%0d_req_ready", c), {31'd0, bus.req_ready}, 32'd0);
         chk($sformatf("bp_hold%0d_resp_valid", c), {30'd0, bus.resp_valid, bus.busy}, 32'd3);
      end
      bus.resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.resp_ready = 1'b0;
      chk("bp_idle_req_ready", {30'd0, bus.req_ready, bus.busy}, 32'd2);
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      chk("bp_new_op_latched", {16'd0, bus.add_a}, 32'h0000_1234);
      @(posedge clk);
      @(negedge clk);
      chk("bp_new_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
      chk("bp_new_result", bus.result, 32'h0000_2345);
      bus.resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.resp_ready = 1'b0;

      // Asynchronous reset in the middle of the high pass.
      bus.req_op_a = 32'h1234_5678; bus.req_op_b = 32'h1111_1111;
      bus.req_sub = 1'b0; bus.req_wide = 1'b1; bus.req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("ar_in_hi_add_a", {16'd0, bus.add_a}, 32'h0000_1234);
      rst_n = 1'b0;
      #1;
      chk("ar_busy", {31'd0, bus.busy}, 32'd0);
      chk("ar_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
      chk("ar_status", {28'd0, bus.status_reg}, 32'd0);
      chk("ar_result", bus.result, 32'd0);
      chk("ar_add_a", {16'd0, bus.add_a}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, r, st, lat);
      chk("ar_next_result", r, 32'h2345_6789);
      chk("ar_next_status", {28'd0, st}, 32'h0000_0004);
      chk("ar_next_latency", lat, 3);

      // Randomized against the reference model.
      for (int i = 0; i < 40; i++) begin
         logic s, w;
         ra = $urandom;
         rb = $urandom;
         if (i % 8 == 0) rb = ra;
         s = 1'($urandom_range(0, 1));
         w = 1'($urandom_range(0, 1));
         model(ra, rb, s, w, exp_r, exp_st);
         do_op(ra, rb, s, w, r, st, lat);
         chk($sformatf("rnd%0d_result", i), r, exp_r);
         chk($sformatf("rnd%0d_status", i), {28'd0, st}, {28'd0, exp_st});
         chk($sformatf("rnd%0d_latency", i), lat, w ? 3 : 2);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
